gfx_wb_pixel_fifo: RTL
======================

Name: gfx_wb_pixel_fifo

Overview:
- Wishbone classic slave in the user project wrapper that buffers pixel/colour words written by the host.
- Drains words through a valid/ready stream, one word per PACE+1 cycles at most.
- Feeds the openGFX430 output stage that drives io_out.
- Provides status (level, empty, full, sticky overflow) so firmware can pace its writes.

Parameters:
DATA_W, 16, width of a pixel word; taken from wbs_dat_i[DATA_W-1:0].
DEPTH, 8, FIFO entries; power of two, at least 2.
BASE_ADR, 32'h0000_0100, byte address of the DATA register; STATUS is at BASE_ADR+4, PACE at BASE_ADR+8.

Ports:
wb_clk_i  in  1  single clock.
wb_rst_i  in  1  asynchronous, active-high reset.
wbs_stb_i  in  1  Wishbone strobe.
wbs_cyc_i  in  1  Wishbone cycle.
wbs_we_i  in  1  write enable.
wbs_sel_i  in  4  byte selects; byte lanes are ignored except that sel==0 makes a write a no-op (ack still given).
wbs_adr_i  in  32  byte address.
wbs_dat_i  in  32  write data.
wbs_ack_o  out  1  transfer acknowledge.
wbs_dat_o  out  32  read data.
pix_valid  out  1  output word valid.
pix_data  out  DATA_W  output word.
pix_ready  in  1  downstream accepts the word when pix_valid&pix_ready.

Behaviour:
- Reset (async assert, released on a clock edge): wbs_ack_o=0, wbs_dat_o=0, pix_valid=0, pix_data=0, FIFO empty, overflow=0, PACE=0, pace counter=0.
- Decode hit: stb&cyc and wbs_adr_i equals BASE_ADR, BASE_ADR+4 or BASE_ADR+8.
- Non-hit: no ack; the request is left to other slaves.
- Ack: wbs_ack_o is registered. It pulses for 1 cycle, the cycle after a hit seen with ack low. A held stb therefore gets ack every other cycle. The register side effect occurs on the same edge that raises ack.
- DATA write pushes wbs_dat_i[DATA_W-1:0].
  - Full and no pop on that edge: word dropped, overflow set to 1.
  - Full with a pop on the same edge: push accepted, level unchanged.
- DATA read returns 0.
- STATUS read:
  - [LW-1:0] level, where LW=$clog2(DEPTH)+1.
  - [16] empty, [17] full, [18] overflow.
  - All other bits 0.
- STATUS write with dat[18]=1 clears overflow. If overflow is set on the same edge, set wins.
- PACE register is 16 bits, R/W, read zero-extended.
- Output register (pix_valid/pix_data):
  - Loads the FIFO head when the FIFO is non-empty, pace counter==0, and (pix_valid==0 or pix_ready==1).
  - On load: pix_valid=1, pace counter := PACE.
  - pix_valid drops after a handshake with no reload.
  - pix_data is held stable while pix_valid&!pix_ready.
- Pace counter decrements by 1 each cycle while nonzero, saturating at 0.
  - PACE=0: back-to-back words.
  - A PACE write affects only the next load.
- Latency: a push into an empty FIFO with idle output gives pix_valid=1 on the 2nd edge after the push edge. Edge 1 writes the FIFO; edge 2 loads the output register.
- Level counts FIFO entries only, not the output register. Maximum buffered words = DEPTH+1.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Full is level==DEPTH.
- Reset mid-operation: all buffered data discarded immediately; an in-flight Wishbone cycle gets no ack.

Test Plan:
- Reset, then one write DATA=0x000A with pix_ready=1 -> ack 1 cycle later; pix_valid high 2 edges after the push; pix_data=0x000A; STATUS reads level 0, empty=1.
- pix_ready=0, write 0,10,...,80 (9 words, DEPTH=8) -> first word sits in the output register, 8 in the FIFO, STATUS=0x20008. A 10th write -> STATUS=0x60008 (overflow). Write STATUS 0x40000 -> overflow=0.
- Then pix_ready=1 -> pix_data sequence 0,10,...,80 on consecutive cycles with no gaps; the 10th word (90) is never output; final STATUS empty=1.
- PACE=3, push 3 words, pix_ready=1 -> handshakes exactly 4 cycles apart.
- Pointer wrap: 20 push/drain cycles of 5 words each -> output equals input order; level never exceeds 5.
- Assert wb_rst_i while 4 words are buffered and pix_valid=1 -> pix_valid=0 and STATUS=0x10000 on the first read after reset; a new push 0x0055 appears first.

Source files
------------

// File: rtl/gfx_wb_pixel_fifo.sv
// Wishbone classic slave that buffers host-written pixel words in a FIFO and
// drains them through a paced valid/ready stream feeding the output stage.
module gfx_wb_pixel_fifo #(
   parameter int          DATA_W   = 16,
   parameter int          DEPTH    = 8,
   parameter logic [31:0] BASE_ADR = 32'h0000_0100
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   output logic              pix_valid,
   output logic [DATA_W-1:0] pix_data,
   input  logic              pix_ready
);

   localparam int          PW         = $clog2(DEPTH);
   localparam int          LW         = PW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [31:0] STATUS_ADR = BASE_ADR + 32'd4;
   localparam logic [31:0] PACE_ADR   = BASE_ADR + 32'd8;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wrPtr_q, wrPtr_d;
   logic [PW-1:0]     rdPtr_q, rdPtr_d;
   logic [LW-1:0]     level_q, level_d;
   logic              ovf_q, ovf_d;
   logic              ack_q, ack_d;
   logic [31:0]       dat_q, dat_d;
   logic [15:0]       pace_q, pace_d;
   logic [15:0]       paceCnt_q, paceCnt_d;
   logic              pixValid_q, pixValid_d;
   logic [DATA_W-1:0] pixData_q, pixData_d;

   logic        isData, isStatus, isPace, hit, access, wrEn;
   logic        empty, full, push, pop, pushAccept, pushDrop, ovfClr, paceWr;
   logic [31:0] rdData;
   logic        unusedBits;

   assign isData   = (wbs_adr_i == BASE_ADR);
   assign isStatus = (wbs_adr_i == STATUS_ADR);
   assign isPace   = (wbs_adr_i == PACE_ADR);
   assign hit      = wbs_stb_i && wbs_cyc_i && (isData || isStatus || isPace);
   // A hit is only serviced while ack is low, so a held strobe acks every other cycle.
   assign access   = hit && !ack_q;
   assign wrEn     = access && wbs_we_i && (wbs_sel_i != 4'b0000);

   assign empty      = (level_q == '0);
   assign full       = (level_q == FULL_LVL);
   assign pop        = !empty && (paceCnt_q == 16'd0) && (!pixValid_q || pix_ready);
   assign push       = wrEn && isData;
   assign pushDrop   = push && full && !pop;
   assign pushAccept = push && !pushDrop;
   assign ovfClr     = wrEn && isStatus && wbs_dat_i[18];
   assign paceWr     = wrEn && isPace;

   assign unusedBits = ^wbs_dat_i;

   always_comb begin
      rdData = '0;
      if (isStatus) begin
         rdData[LW-1:0] = level_q;
         rdData[16]     = empty;
         rdData[17]     = full;
         rdData[18]     = ovf_q;
      end else if (isPace) begin
         rdData[15:0] = pace_q;
      end
   end

   always_comb begin
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      ovf_d      = ovf_q;
      pace_d     = pace_q;
      paceCnt_d  = paceCnt_q;
      pixValid_d = pixValid_q;
      pixData_d  = pixData_q;
      ack_d      = access;
      dat_d      = '0;
      if (access && !wbs_we_i) dat_d = rdData;
      if (pushAccept) wrPtr_d = wrPtr_q + PW'(1);
      if (pop) rdPtr_d = rdPtr_q + PW'(1);
      level_d = level_q + LW'(pushAccept) - LW'(pop);
      if (ovfClr) ovf_d = 1'b0;
      if (pushDrop) ovf_d = 1'b1;
      if (paceWr) pace_d = wbs_dat_i[15:0];
      // Loading the output register restarts the pace count from the PACE value in force now.
      if (pop) begin
         pixValid_d = 1'b1;
         pixData_d  = mem_q[rdPtr_q];
         paceCnt_d  = pace_q;
      end else begin
         if (pixValid_q && pix_ready) pixValid_d = 1'b0;
         if (paceCnt_q != 16'd0) paceCnt_d = paceCnt_q - 16'd1;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         level_q    <= '0;
         ovf_q      <= 1'b0;
         ack_q      <= 1'b0;
         dat_q      <= '0;
         pace_q     <= '0;
         paceCnt_q  <= '0;
         pixValid_q <= 1'b0;
         pixData_q  <= '0;
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         level_q    <= level_d;
         ovf_q      <= ovf_d;
         ack_q      <= ack_d;
         dat_q      <= dat_d;
         pace_q     <= pace_d;
         paceCnt_q  <= paceCnt_d;
         pixValid_q <= pixValid_d;
         pixData_q  <= pixData_d;
      end
   end

   // Storage needs no reset; the pointers and level define what is valid.
   always_ff @(posedge wb_clk_i) begin
      if (pushAccept) mem_q[wrPtr_q] <= wbs_dat_i[DATA_W-1:0];
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign pix_valid = pixValid_q;
   assign pix_data  = pixData_q;

endmodule
